// File: rtl/yadmc_event_sync_pkg.sv
// Shared constants and helpers for the multi-channel event synchroniser.
// Edge-mode encodings and a constant-friendly clog2.
package yadmc_event_sync_pkg;

    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_RISE  = 2'b01;
    localparam logic [1:0] MODE_FALL  = 2'b10;
    localparam logic [1:0] MODE_ANY   = 2'b11;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/yadmc_event_sync_chan.sv
// One channel: sync chain, glitch filter, edge decode and sticky
// pending/overrun flags with acknowledge.
module yadmc_event_sync_chan
    import yadmc_event_sync_pkg::*;
#(
    parameter int         STAGES = 2,
    parameter int         FILTER = 3,
    parameter logic [1:0] MODE   = MODE_ANY
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    input  logic ack,
    input  logic prime_done,
    output logic level,
    output logic pulse,
    output logic pending,
    output logic overrun
);

    localparam int FLT = (FILTER > 1) ? FILTER : 1;
    localparam int CW  = clog2((FILTER > 2) ? FILTER : 2);
    localparam logic [CW-1:0] THRESH = CW'(FLT - 1);

    logic [STAGES-1:0] chain;
    logic [CW-1:0]     cnt;
    logic              sync_out;
    logic              sync_next;
    logic              accept;
    logic              level_next;
    logic              event_hit;

    assign sync_out  = chain[STAGES-1];
    assign sync_next = chain[STAGES-2];

    always_comb begin
        accept     = prime_done && (sync_out != level) && (cnt == THRESH);
        level_next = accept ? sync_out : level;
        event_hit  = 1'b0;
        unique case (MODE)
            MODE_LEVEL: event_hit = prime_done & level_next;
            MODE_RISE:  event_hit = accept & sync_out;
            MODE_FALL:  event_hit = accept & ~sync_out;
            default:    event_hit = accept;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain   <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            if (!prime_done) begin
                // Track the chain so a level held through reset is no event
                level <= sync_next;
                cnt   <= '0;
                pulse <= 1'b0;
            end else begin
                if (sync_out == level) begin
                    cnt <= '0;
                end else if (cnt == THRESH) begin
                    level <= sync_out;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                pulse   <= (MODE == MODE_LEVEL) ? level_next : event_hit;
                pending <= (pending & ~ack) | event_hit;
                overrun <= (overrun & ~ack) | (event_hit & pending & ~ack);
            end
        end
    end

endmodule

// File: rtl/yadmc_event_sync.sv
// Multi-channel event synchroniser at the controller clock boundary.
// Shared priming counter, per-channel instances and the irq OR.
module yadmc_event_sync
    import yadmc_event_sync_pkg::*;
#(
    parameter int                    CHANNELS  = 4,
    parameter int                    STAGES    = 2,
    parameter int                    FILTER    = 3,
    parameter logic [2*CHANNELS-1:0] EDGE_MODE = {CHANNELS{2'b11}}
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [CHANNELS-1:0] async_in,
    input  logic [CHANNELS-1:0] ack,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] overrun,
    output logic                irq
);

    localparam int PW = clog2(STAGES + 1);

    logic [PW-1:0] prime_cnt;
    logic          prime_done;

    assign prime_done = (prime_cnt == PW'(STAGES));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            prime_cnt <= '0;
        end else if (!prime_done) begin
            prime_cnt <= prime_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        yadmc_event_sync_chan #(
            .STAGES (STAGES),
            .FILTER (FILTER),
            .MODE   (EDGE_MODE[2*i +: 2])
        ) u_chan (
            .clk        (sys_clk),
            .rst        (sys_rst),
            .async_in   (async_in[i]),
            .ack        (ack[i]),
            .prime_done (prime_done),
            .level      (level[i]),
            .pulse      (pulse[i]),
            .pending    (pending[i]),
            .overrun    (overrun[i])
        );
    end

    assign irq = |pending;

endmodule

// File: doc/yadmc_event_sync.md
Name: yadmc_event_sync

Overview:
Multi-channel event synchroniser. Brings CHANNELS asynchronous inputs into the sys_clk domain. Each input can be a level, a toggle-encoded flag from another domain, or a raw strobe line.
- Per channel: configurable synchroniser depth, glitch filter, edge-detect mode, and a sticky pending/overrun latch with acknowledge.
- Sits at the memory controller's clock-domain boundary and feeds its interrupt/status logic.

Parameters:
CHANNELS, 4, number of independent channels.
STAGES, 2, synchroniser flip-flops per channel; legal values are 2 and above.
FILTER, 3, consecutive stable cycles required before a change is accepted; 0 and 1 both mean no filtering.
EDGE_MODE, {CHANNELS{2'b11}}, 2 bits per channel: 00 level, 01 rising, 10 falling, 11 any edge (toggle decode).

Ports:
sys_clk  in  1  single clock.
sys_rst  in  1  asynchronous, active-high reset.
async_in  in  CHANNELS  asynchronous inputs.
ack  in  CHANNELS  per-channel clear for pending/overrun (sys_clk domain).
level  out  CHANNELS  synchronised, filtered level.
pulse  out  CHANNELS  registered event strobe.
pending  out  CHANNELS  sticky event flag.
overrun  out  CHANNELS  sticky flag: an event arrived while pending was already set.
irq  out  1  OR of pending.

Behaviour:
- Reset: sys_rst asserted clears immediately (asynchronously) the sync chains, level, filter counters, pulse, pending, overrun and the prime counter. irq=0.
- Priming: the first STAGES sys_clk edges after sys_rst deasserts are priming edges.
  - On these edges, level <= sync output, filter counters <= 0, pulse stays 0, pending/overrun do not change.
  - An input held constant through reset therefore never produces an event.
- Sync chain: shift register of STAGES bits per channel; sync_out is the last stage.
- Filter, per channel, after priming:
  - If sync_out == level, cnt <= 0.
  - Else, if cnt == max(FILTER,1)-1, then level <= sync_out and cnt <= 0.
  - Else, cnt <= cnt+1.
  - Width of cnt is clog2(max(FILTER,2)).
- Glitch rejection: a difference lasting fewer than max(FILTER,1) cycles at sync_out is discarded.
- Latency: an input change sampled at edge n updates level and pulse at edge n+STAGES-1+max(FILTER,1).
- Event definition, evaluated on the edge where level changes:
  - 01: a 0->1 change is an event.
  - 10: a 1->0 change is an event.
  - 11: any change is an event.
  - 00: there are no edge events. pulse mirrors level, and pending is set on every cycle that level is 1.
- pulse: registered, high for exactly one cycle per event in edge modes.
- pending <= (pending & ~ack) | event. When ack and event coincide, set wins, so no event is lost.
- overrun <= (overrun & ~ack) | (event & pending & ~ack). When ack and event coincide, overrun is not set. ack clears both flags on the next edge.
- irq: combinational OR of the pending registers. No other combinational paths from inputs to outputs.
- Channels are fully independent; simultaneous events on any number of channels are all captured.
- Reset mid-filter or mid-priming: all state is cleared and priming restarts after deassertion.

Decomposition:
- Shared header/package holds:
  - mode constants: MODE_LEVEL=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_ANY=2'b11;
  - a clog2 function.
- One sub-module, yadmc_event_sync_chan: sync chain, filter, edge detect, pending/overrun for one channel.
  - Parameters: STAGES, FILTER, MODE.
  - Input: a prime-done flag.
- The top level holds the shared prime counter and generates CHANNELS instances and irq.

Test Plan:
All scenarios use CHANNELS=4, STAGES=2, FILTER=3, EDGE_MODE={11,01,10,01} for channels 3..0.
1. Reset priming: hold async_in=4'b0101 through reset, release reset -> level=4'b0101 by edge 2; pulse, pending and irq stay 0 for 50 cycles.
2. Rising event: ch0 0->1 sampled at edge n -> level[0] and pulse[0] rise at edge n+4; pulse[0] high for 1 cycle; pending[0]=1; irq=1; ch2 (falling mode) unaffected.
3. Glitch rejection: ch1 high for 2 cycles, then low -> level[1] stays 0 and pulse[1] stays 0. ch1 high for 3 cycles, then low -> one pulse[1] (rising mode) at the accepting edge.
4. Toggle overrun: toggle ch3 twice, 10 cycles apart, with no ack -> two pulse[3] strobes; pending[3]=1; overrun[3]=1 after the second. Pulse ack[3] -> pending[3]=0 and overrun[3]=0 at the next edge, irq=0.
5. Ack collision: assert ack[3] on the same edge that ch3's next event registers -> pending[3]=1 and overrun[3]=0.
6. Mid-operation reset: assert sys_rst while ch0's filter count is 2 -> all outputs 0 immediately, without waiting for a clock. After release, with async_in=0001 -> no pulse, level=0001 after 2 edges.
